// File: rtl/memory_access.sv
// MEM stage of a 5-stage MIPS pipeline: EX/MEM register, branch resolution,
// word-addressed synchronous data memory and the MEM/WB register feeding writeback.
module memory_access #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] branch_or_not_address,
  input  logic        zero,
  input  logic [31:0] ALU_result,
  input  logic [4:0]  write_register,
  input  logic [31:0] read_data_2_ex,
  input  logic        ctrl_branch_ex,
  input  logic        ctrl_memRead_ex,
  input  logic        ctrl_memWrite_ex,
  input  logic        ctrl_regWrite_ex,
  input  logic        ctrl_memToReg_ex,
  input  logic        stall,
  input  logic        flush,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic [31:0] read_data_mem_wb,
  output logic [31:0] ALU_result_mem_wb,
  output logic [4:0]  write_register_mem_wb,
  output logic        ctrl_regWrite_mem_wb,
  output logic        ctrl_memToReg_mem_wb,
  output logic        mem_error
);

  logic [31:0]       mem [DEPTH];

  logic [31:0]       ex_target_r;
  logic [31:0]       ex_alu_r;
  logic [31:0]       ex_store_data_r;
  logic [4:0]        ex_write_register_r;
  logic              ex_zero_r;
  logic              ex_branch_r;
  logic              ex_mem_read_r;
  logic              ex_mem_write_r;
  logic              ex_reg_write_r;
  logic              ex_mem_to_reg_r;

  logic [ADDR_W-1:0] word_index_s;
  logic              misaligned_s;
  logic              advance_s;
  logic              do_store_s;
  logic              do_load_s;
  logic              access_error_s;

  function automatic logic is_misaligned(input logic [1:0] byte_offset);
    return byte_offset != 2'b00;
  endfunction

  // A flush always moves the pipeline, even when a stall is requested in the same cycle.
  always_comb begin
    word_index_s   = ex_alu_r[ADDR_W+1:2];
    misaligned_s   = is_misaligned(ex_alu_r[1:0]);
    advance_s      = flush | ~stall;
    do_store_s     = advance_s & ex_mem_write_r & ~misaligned_s;
    do_load_s      = ex_mem_read_r & ~misaligned_s;
    access_error_s = advance_s & (ex_mem_read_r | ex_mem_write_r) & misaligned_s;
    pc_src         = ex_branch_r & ex_zero_r;
    branch_target  = ex_target_r;
  end

  // EX/MEM register; a flush loads a bubble by clearing only the control bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_target_r         <= 32'd0;
      ex_alu_r            <= 32'd0;
      ex_store_data_r     <= 32'd0;
      ex_write_register_r <= 5'd0;
      ex_zero_r           <= 1'b0;
      ex_branch_r         <= 1'b0;
      ex_mem_read_r       <= 1'b0;
      ex_mem_write_r      <= 1'b0;
      ex_reg_write_r      <= 1'b0;
      ex_mem_to_reg_r     <= 1'b0;
    end else if (advance_s) begin
      ex_target_r         <= branch_or_not_address;
      ex_alu_r            <= ALU_result;
      ex_store_data_r     <= read_data_2_ex;
      ex_write_register_r <= write_register;
      ex_zero_r           <= zero;
      ex_branch_r         <= ctrl_branch_ex   & ~flush;
      ex_mem_read_r       <= ctrl_memRead_ex  & ~flush;
      ex_mem_write_r      <= ctrl_memWrite_ex & ~flush;
      ex_reg_write_r      <= ctrl_regWrite_ex & ~flush;
      ex_mem_to_reg_r     <= ctrl_memToReg_ex & ~flush;
    end
  end

  // MEM/WB register; the array read sees the pre-store word (read-before-write).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_mem_wb      <= 32'd0;
      ALU_result_mem_wb     <= 32'd0;
      write_register_mem_wb <= 5'd0;
      ctrl_regWrite_mem_wb  <= 1'b0;
      ctrl_memToReg_mem_wb  <= 1'b0;
      mem_error             <= 1'b0;
    end else begin
      if (advance_s) begin
        read_data_mem_wb      <= do_load_s ? mem[word_index_s] : 32'd0;
        ALU_result_mem_wb     <= ex_alu_r;
        write_register_mem_wb <= ex_write_register_r;
        ctrl_regWrite_mem_wb  <= ex_reg_write_r;
        ctrl_memToReg_mem_wb  <= ex_mem_to_reg_r;
      end
      if (access_error_s) begin
        mem_error <= 1'b1;
      end
    end
  end

  // Data array; contents survive reset, and reset held low blocks any store.
  always_ff @(posedge clk) begin
    if (reset && do_store_s) begin
      mem[word_index_s] <= ex_store_data_r;
    end
  end

endmodule
